fx2_cmd_sequencer: RTL and testbench

//  Parses the host command byte stream from the FX2 OUT-FIFO reader and drives the timetag register bus.

---
 rtl/fx2_cmd_pkg.sv | 29 ++
 rtl/fx2_reply_serializer.sv | 51 +++++
 rtl/fx2_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_fx2_cmd_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_cmd_pkg.sv
// Shared constants and types for the FX2 host command sequencer.
package fx2_cmd_pkg;

    // Frame bytes
    localparam logic [7:0] CMD_MAGIC = 8'hAA;
    localparam logic [7:0] OP_READ   = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;

    // Timetag register map
    localparam logic [7:0] REG_VERSION      = 8'd1;
    localparam logic [7:0] REG_CLOCKRATE    = 8'd2;
    localparam logic [7:0] REG_CAPTURE_CTRL = 8'd3;
    localparam logic [7:0] REG_STROBE_EN    = 8'd4;

    // Each state is named after the last frame field consumed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MAGIC_OK = 3'd1,
        ST_OPCODE   = 3'd2,
        ST_ADDR     = 3'd3,
        ST_BUS      = 3'd4,
        ST_REPLY    = 3'd5
    } seq_state_t;

    function automatic logic is_valid_opcode(input logic [7:0] b);
        return (b == OP_READ) || (b == OP_WRITE);
    endfunction

endpackage

// File: rtl/fx2_reply_serializer.sv
// Turns a 32-bit read result into four reply bytes, LSB first, on a
// valid/ready stream. A byte moves only when rsp_valid & rsp_ready are both
// high at a clock edge; rsp_valid stays high until all four bytes have moved.
module fx2_reply_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    output logic        done
);

    logic [31:0] word_q;
    logic [1:0]  byte_idx;
    logic        active;

    // Capture a word on load, then step the byte index on each handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q   <= '0;
            byte_idx <= '0;
            active   <= 1'b0;
        end else if (load) begin
            word_q   <= load_data;
            byte_idx <= '0;
            active   <= 1'b1;
        end else if (active && rsp_ready) begin
            if (byte_idx == 2'd3) begin
                active <= 1'b0;
            end
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // Select the current byte and flag the final handshake.
    always_comb begin
        rsp_data = 8'h00;
        case (byte_idx)
            2'd0: rsp_data = word_q[7:0];
            2'd1: rsp_data = word_q[15:8];
            2'd2: rsp_data = word_q[23:16];
            2'd3: rsp_data = word_q[31:24];
            default: rsp_data = 8'h00;
        endcase
        rsp_valid = active;
        done      = active && rsp_ready && (byte_idx == 2'd3);
    end

endmodule

// File: rtl/fx2_cmd_sequencer.sv
// Parses 4-byte host frames (magic, opcode, address, data) from the FX2
// OUT-FIFO reader, runs one register bus cycle per frame and streams read
// results back to the IN-FIFO writer. cmd_data is taken when
// cmd_valid & cmd_ready are both high at a clock edge.
module fx2_cmd_sequencer
    import fx2_cmd_pkg::*;
#(
    parameter int FRAME_TIMEOUT = 1024,  // at least 2
    parameter int ACK_TIMEOUT   = 64,
    parameter int ERR_W         = 8
) (
    input  logic             fx2_clk,
    input  logic             reset,
    input  logic [7:0]       cmd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [7:0]       reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_wr,
    output logic             reg_rd,
    input  logic [31:0]      reg_rdata,
    input  logic             reg_ack,
    output logic [7:0]       rsp_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [ERR_W-1:0] err_count,
    output seq_state_t       dbg_state
);

    localparam int FC_W = $clog2(FRAME_TIMEOUT);
    localparam int AC_W = $clog2(ACK_TIMEOUT + 1);

    seq_state_t      state, state_nxt;
    logic [FC_W-1:0] frame_cnt;
    logic [AC_W-1:0] ack_cnt;
    logic            is_read_q;

    logic byte_acc, in_frame, frame_to, ack_to, bad_magic, bad_op, err_inc;
    logic ser_load, ser_done;
    logic [31:0] ser_word;

    assign byte_acc  = cmd_valid && cmd_ready;
    assign in_frame  = (state == ST_MAGIC_OK) || (state == ST_OPCODE) || (state == ST_ADDR);
    // A byte arriving on the limit cycle wins over the timeout.
    assign frame_to  = in_frame && !byte_acc && (frame_cnt == FC_W'(FRAME_TIMEOUT - 1));
    assign ack_to    = (state == ST_BUS) && !reg_ack && (ack_cnt == AC_W'(ACK_TIMEOUT));
    assign bad_magic = (state == ST_IDLE) && byte_acc && (cmd_data != CMD_MAGIC);
    assign bad_op    = (state == ST_MAGIC_OK) && byte_acc && !is_valid_opcode(cmd_data);
    assign err_inc   = bad_magic || bad_op || frame_to || ack_to;

    // A timed-out read still answers, with all ones.
    assign ser_load  = (state == ST_BUS) && is_read_q && (reg_ack || ack_to);
    assign ser_word  = reg_ack ? reg_rdata : 32'hFFFF_FFFF;

    // State register.
    always_ff @(posedge fx2_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (byte_acc && cmd_data == CMD_MAGIC) state_nxt = ST_MAGIC_OK;
            end
            ST_MAGIC_OK: begin
                if (byte_acc) state_nxt = is_valid_opcode(cmd_data) ? ST_OPCODE : ST_IDLE;
                else if (frame_to) state_nxt = ST_IDLE;
            end
            ST_OPCODE: begin
                if (byte_acc) state_nxt = ST_ADDR;
                else if (frame_to) state_nxt = ST_IDLE;
            end
            ST_ADDR: begin
                if (byte_acc) state_nxt = ST_BUS;
                else if (frame_to) state_nxt = ST_IDLE;
            end
            ST_BUS: begin
                if (reg_ack || ack_to) state_nxt = is_read_q ? ST_REPLY : ST_IDLE;
            end
            ST_REPLY: begin
                if (ser_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; the strobe is the first BUS cycle only.
    always_comb begin
        cmd_ready = in_frame || (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        reg_rd    = (state == ST_BUS) && (ack_cnt == '0) && is_read_q;
        reg_wr    = (state == ST_BUS) && (ack_cnt == '0) && !is_read_q;
        dbg_state = state;
    end

    // Latch opcode, address and write data as the frame arrives.
    always_ff @(posedge fx2_clk) begin
        if (reset) begin
            is_read_q <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else if (byte_acc) begin
            if (state == ST_MAGIC_OK) is_read_q <= (cmd_data == OP_READ);
            if (state == ST_OPCODE)   reg_addr  <= cmd_data;
            if (state == ST_ADDR && !is_read_q) reg_wdata <= cmd_data;
        end
    end

    // Inter-byte idle counter and bus-wait counter.
    always_ff @(posedge fx2_clk) begin
        if (reset) begin
            frame_cnt <= '0;
            ack_cnt   <= '0;
        end else begin
            frame_cnt <= (!in_frame || byte_acc) ? '0 : frame_cnt + 1'b1;
            ack_cnt   <= (state == ST_BUS && state_nxt == ST_BUS) ? ack_cnt + 1'b1 : '0;
        end
    end

    // Saturating error counter; simultaneous causes count once.
    always_ff @(posedge fx2_clk) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_inc && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
        end
    end

    fx2_reply_serializer u_reply (
        .clk       (fx2_clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ser_word),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .done      (ser_done)
    );

endmodule

// File: tb/tb_fx2_cmd_sequencer.sv
// Directed bench for fx2_cmd_sequencer with a bus responder, a reply
// scoreboard and a bus-strobe scoreboard.
module tb_fx2_cmd_sequencer;
    import fx2_cmd_pkg::*;

    localparam int FRAME_TIMEOUT = 1024;
    localparam int ACK_TIMEOUT   = 64;
    localparam int ERR_W         = 8;

    logic             fx2_clk = 1'b0;
    logic             reset = 1'b1;
    logic [7:0]       cmd_data = 8'h00;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       reg_addr, reg_wdata;
    logic             reg_wr, reg_rd;
    logic [31:0]      reg_rdata = 32'h0;
    logic             reg_ack = 1'b0;
    logic [7:0]       rsp_data;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             busy;
    logic [ERR_W-1:0] err_count;
    seq_state_t       dbg_state;

    fx2_cmd_sequencer #(
        .FRAME_TIMEOUT (FRAME_TIMEOUT),
        .ACK_TIMEOUT   (ACK_TIMEOUT),
        .ERR_W         (ERR_W)
    ) dut (
        .fx2_clk   (fx2_clk),
        .reset     (reset),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 fx2_clk = ~fx2_clk;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_rsp_q[$];
    logic [17:0] exp_bus_q[$];   // {rd, wr, addr, wdata}

    bit          ack_en     = 1'b1;
    int          ack_delay  = 0;
    logic [31:0] rdata_val  = 32'h0;
    bit          rsp_toggle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] bus_exp(input bit rd, input bit wr,
                                            input logic [7:0] addr, input logic [7:0] wdata);
        return {rd, wr, addr, wdata};
    endfunction

    // ---------------- monitors ----------------
    // Bus strobe monitor: every strobe must match the next expected bus cycle.
    initial forever begin
        @(negedge fx2_clk);
        if (reg_rd || reg_wr) begin
            if (exp_bus_q.size() == 0) begin
                check("bus_unexpected_strobe", {reg_rd, reg_wr}, 32'h0);
            end else begin
                logic [17:0] e;
                e = exp_bus_q.pop_front();
                check("bus_rd_wr", {reg_rd, reg_wr}, e[17:16]);
                check("bus_addr", reg_addr, e[15:8]);
                if (e[16]) check("bus_wdata", reg_wdata, e[7:0]);
            end
        end
    end

    // Reply monitor: every handshaked byte must match the next expected byte.
    initial forever begin
        @(negedge fx2_clk);
        if (rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected_byte", {24'h0, rsp_data} | 32'h100, 32'h0);
            end else begin
                check("rsp_byte", rsp_data, exp_rsp_q.pop_front());
            end
            check("cmd_ready_during_reply", cmd_ready, 1'b0);
        end
    end

    // Bus responder: acks each strobe after ack_delay cycles (0 = same cycle).
    initial forever begin
        @(negedge fx2_clk);
        if ((reg_rd || reg_wr) && ack_en) begin
            if (ack_delay > 0) begin
                repeat (ack_delay) @(posedge fx2_clk);
                #1;
            end
            reg_rdata = rdata_val;
            reg_ack   = 1'b1;
            @(posedge fx2_clk);
            #1 reg_ack = 1'b0;
        end
    end

    // Reply backpressure pattern.
    initial forever begin
        @(posedge fx2_clk);
        #1;
        if (rsp_toggle) rsp_ready = ~rsp_ready;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        int guard = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (!acc && guard < 2000) begin
            @(negedge fx2_clk);
            acc = cmd_ready;
            @(posedge fx2_clk);
            guard++;
        end
        #1 cmd_valid = 1'b0;
        if (!acc) check("send_byte_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic push_reply(input logic [31:0] w);
        exp_rsp_q.push_back(w[7:0]);
        exp_rsp_q.push_back(w[15:8]);
        exp_rsp_q.push_back(w[23:16]);
        exp_rsp_q.push_back(w[31:24]);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge fx2_clk);
            if (!busy && exp_rsp_q.size() == 0 && exp_bus_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("wait_idle_timeout", 32'h0, 32'h1);
        @(posedge fx2_clk);
        #1;
    endtask

    // Called right after the last frame byte is taken: the strobe is due now,
    // then the number of cycles until the first rsp_valid is measured.
    task automatic measure_rsp_latency(input string name, input int exp_lat);
        int lat = 0;
        @(negedge fx2_clk);
        check({name, "_rd_strobe"}, reg_rd, 1'b1);
        for (int i = 1; i <= 300; i++) begin
            @(negedge fx2_clk);
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check(name, lat, exp_lat);
        @(posedge fx2_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge fx2_clk);
        #1 reset = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        repeat (3) @(posedge fx2_clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_strobes", {reg_rd, reg_wr}, 2'b00);
        check("reset_err_count", err_count, 0);
        check("reset_reg_addr", reg_addr, 8'h00);
        check("reset_state", dbg_state, ST_IDLE);
        reset = 1'b0;

        // 1. Garbage then a version read
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("t1_garbage_errors", err_count, 3);
        check("t1_garbage_idle", busy, 1'b0);
        ack_delay = 0;
        rdata_val = 32'h0000_0002;
        exp_bus_q.push_back(bus_exp(1'b1, 1'b0, REG_VERSION, 8'h00));
        push_reply(32'h0000_0002);
        send_frame(CMD_MAGIC, OP_READ, REG_VERSION, 8'h00);
        measure_rsp_latency("t1_read_latency", 1);
        wait_idle(100);

        // 2. Two writes
        ack_delay = 2;
        exp_bus_q.push_back(bus_exp(1'b0, 1'b1, REG_CAPTURE_CTRL, 8'h04));
        send_frame(CMD_MAGIC, OP_WRITE, REG_CAPTURE_CTRL, 8'h04);
        @(negedge fx2_clk);
        check("t2_wr_latency", reg_wr, 1'b1);
        wait_idle(100);
        exp_bus_q.push_back(bus_exp(1'b0, 1'b1, REG_STROBE_EN, 8'h0F));
        send_frame(CMD_MAGIC, OP_WRITE, REG_STROBE_EN, 8'h0F);
        wait_idle(100);
        check("t2_err_unchanged", err_count, 3);

        // 3. Clockrate read with toggling rsp_ready
        ack_delay  = 1;
        rdata_val  = 32'h05F5_E100;
        rsp_toggle = 1'b1;
        exp_bus_q.push_back(bus_exp(1'b1, 1'b0, REG_CLOCKRATE, 8'h00));
        push_reply(32'h05F5_E100);
        send_frame(CMD_MAGIC, OP_READ, REG_CLOCKRATE, 8'h00);
        wait_idle(200);
        rsp_toggle = 1'b0;
        @(posedge fx2_clk);
        #2 rsp_ready = 1'b1;
        check("t3_cmd_ready_after", cmd_ready, 1'b1);

        // 4. Bad opcode, then a normal write
        do_reset();
        send_byte(CMD_MAGIC);
        send_byte(8'h07);
        check("t4_bad_op_err", err_count, 1);
        check("t4_bad_op_idle", busy, 1'b0);
        ack_delay = 0;
        exp_bus_q.push_back(bus_exp(1'b0, 1'b1, REG_CAPTURE_CTRL, 8'h02));
        send_frame(CMD_MAGIC, OP_WRITE, REG_CAPTURE_CTRL, 8'h02);
        wait_idle(100);
        check("t4_err_after_write", err_count, 1);

        // 5. Frame timeout, and a byte landing exactly on the limit
        do_reset();
        send_byte(CMD_MAGIC);
        send_byte(OP_WRITE);
        repeat (FRAME_TIMEOUT - 1) @(posedge fx2_clk);
        #1;
        check("t5_no_early_timeout", busy, 1'b1);
        @(posedge fx2_clk);
        #1;
        check("t5_timeout_state", dbg_state, ST_IDLE);
        check("t5_timeout_err", err_count, 1);
        send_byte(CMD_MAGIC);
        send_byte(OP_WRITE);
        repeat (FRAME_TIMEOUT - 1) @(posedge fx2_clk);
        #1;
        send_byte(REG_CAPTURE_CTRL);
        check("t5_limit_byte_err", err_count, 1);
        check("t5_limit_byte_busy", busy, 1'b1);
        exp_bus_q.push_back(bus_exp(1'b0, 1'b1, REG_CAPTURE_CTRL, 8'h07));
        send_byte(8'h07);
        wait_idle(100);

        // 6. Ack timeout read, then reset in the middle of a reply
        do_reset();
        ack_en = 1'b0;
        exp_bus_q.push_back(bus_exp(1'b1, 1'b0, REG_STROBE_EN, 8'h00));
        push_reply(32'hFFFF_FFFF);
        send_frame(CMD_MAGIC, OP_READ, REG_STROBE_EN, 8'h00);
        wait_idle(300);
        check("t6_ack_timeout_err", err_count, 1);
        rsp_ready = 1'b0;
        exp_bus_q.push_back(bus_exp(1'b1, 1'b0, REG_STROBE_EN, 8'h00));
        send_frame(CMD_MAGIC, OP_READ, REG_STROBE_EN, 8'h00);
        measure_rsp_latency("t6_ack_timeout_latency", ACK_TIMEOUT + 1);
        check("t6_timeout_data", rsp_data, 8'hFF);
        check("t6_err_before_reset", err_count, 2);
        reset = 1'b1;
        @(posedge fx2_clk);
        @(negedge fx2_clk);
        check("t6_reset_rsp_valid", rsp_valid, 1'b0);
        check("t6_reset_err", err_count, 0);
        check("t6_reset_cmd_ready", cmd_ready, 1'b1);
        @(posedge fx2_clk);
        #1 reset = 1'b0;
        rsp_ready = 1'b1;
        ack_en = 1'b1;
        repeat (5) @(posedge fx2_clk);
        #1;
        check("t6_no_reply_after_reset", rsp_valid, 1'b0);

        // 7. err_count saturation
        do_reset();
        for (int i = 0; i < 260; i++) send_byte(8'hFF);
        check("t7_err_saturated", err_count, 255);

        check("end_bus_queue_empty", exp_bus_q.size(), 0);
        check("end_rsp_queue_empty", exp_rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
